// File: rtl/demux_writeback.sv
// Purpose : write-side demux for the bitty datapath; queues tagged result writes and
//           commits them in order into reg0..reg7, immediate and def_val.
// Latency : one cycle minimum (accept on edge N, earliest commit on edge N+1), no bypass.
// Backpressure: wr_ready = queue not full, from registered count only; commit_en low stalls commits.
// Ports   : clk/rst_n (async active-low); wr_valid/wr_ready/wr_sel/wr_data write handshake;
//           commit_en head-commit enable; clear_err clears sticky err_sel;
//           reg0..reg7/immediate/def_val bank outputs; busy = queue non-empty.
module demux_writeback #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [3:0]        wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              commit_en,
  input  logic              clear_err,
  output logic [DATA_W-1:0] reg0,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic [DATA_W-1:0] reg3,
  output logic [DATA_W-1:0] reg4,
  output logic [DATA_W-1:0] reg5,
  output logic [DATA_W-1:0] reg6,
  output logic [DATA_W-1:0] reg7,
  output logic [DATA_W-1:0] immediate,
  output logic [DATA_W-1:0] def_val,
  output logic              busy,
  output logic              err_sel
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int NDST = 10;  // reg0..reg7, immediate (8), def_val (9)
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [3:0]        r_q_sel [DEPTH];
  logic [DATA_W-1:0] r_q_dat [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [DATA_W-1:0] r_bank  [NDST];
  logic              r_err;

  logic              w_acc;
  logic              w_inv;
  logic              w_push;
  logic              w_pop;
  logic [3:0]        w_head_sel;
  logic [DATA_W-1:0] w_head_dat;

  // Ready depends only on the registered count: a same-cycle pop does not reopen a full queue.
  assign wr_ready   = (r_count != FULL);
  assign w_acc      = wr_valid & wr_ready;
  assign w_inv      = (wr_sel > 4'd9);
  // Invalid selects complete the handshake but are dropped instead of queued.
  assign w_push     = w_acc & ~w_inv;
  assign w_pop      = commit_en & (r_count != '0);
  assign w_head_sel = r_q_sel[r_rptr];
  assign w_head_dat = r_q_dat[r_rptr];

  // Queue payload needs no reset: occupancy is tracked by r_count/pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_sel[r_wptr] <= wr_sel;
      r_q_dat[r_wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < NDST; i++) r_bank[i] <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == LAST) ? '0 : r_wptr + PW'(1);
      if (w_pop)  r_rptr <= (r_rptr == LAST) ? '0 : r_rptr + PW'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      // Set beats clear when an invalid write lands on the same edge.
      if (w_acc && w_inv) r_err <= 1'b1;
      else if (clear_err) r_err <= 1'b0;

      for (int i = 0; i < NDST; i++) begin
        if (w_pop && (w_head_sel == 4'(i))) r_bank[i] <= w_head_dat;
      end
    end
  end

  assign reg0      = r_bank[0];
  assign reg1      = r_bank[1];
  assign reg2      = r_bank[2];
  assign reg3      = r_bank[3];
  assign reg4      = r_bank[4];
  assign reg5      = r_bank[5];
  assign reg6      = r_bank[6];
  assign reg7      = r_bank[7];
  assign immediate = r_bank[8];
  assign def_val   = r_bank[9];
  assign busy      = (r_count != '0);
  assign err_sel   = r_err;

endmodule

// File: tb/tb_demux_writeback.sv
// Bench for demux_writeback: directed scenarios with literal expectations, then a randomized
// run; a queue-based reference model is compared against every output on each falling edge.
module tb_demux_writeback;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_valid = 1'b0;
  logic              wr_ready;
  logic [3:0]        wr_sel = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              commit_en = 1'b0;
  logic              clear_err = 1'b0;
  logic [DATA_W-1:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7, immediate, def_val;
  logic              busy;
  logic              err_sel;

  demux_writeback #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sel(wr_sel), .wr_data(wr_data),
    .commit_en(commit_en), .clear_err(clear_err),
    .reg0(reg0), .reg1(reg1), .reg2(reg2), .reg3(reg3),
    .reg4(reg4), .reg5(reg5), .reg6(reg6), .reg7(reg7),
    .immediate(immediate), .def_val(def_val),
    .busy(busy), .err_sel(err_sel)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit run_cmp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]        sel;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t              m_q[$];
  logic [DATA_W-1:0] m_bank [10];
  bit                m_err = 1'b0;

  initial for (int i = 0; i < 10; i++) m_bank[i] = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      for (int i = 0; i < 10; i++) m_bank[i] = '0;
      m_err = 1'b0;
    end else begin
      bit   rdy, acc, pop;
      ent_t e;
      rdy = (m_q.size() < DEPTH);
      acc = wr_valid && rdy;
      pop = commit_en && (m_q.size() > 0);
      if (pop) begin
        e = m_q.pop_front();
        m_bank[e.sel] = e.d;
      end
      if (acc && wr_sel >= 4'd10) m_err = 1'b1;
      else if (clear_err) m_err = 1'b0;
      if (acc && wr_sel < 4'd10) begin
        e.sel = wr_sel;
        e.d   = wr_data;
        m_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("reg0", 32'(reg0), 32'(m_bank[0]));
      chk("reg1", 32'(reg1), 32'(m_bank[1]));
      chk("reg2", 32'(reg2), 32'(m_bank[2]));
      chk("reg3", 32'(reg3), 32'(m_bank[3]));
      chk("reg4", 32'(reg4), 32'(m_bank[4]));
      chk("reg5", 32'(reg5), 32'(m_bank[5]));
      chk("reg6", 32'(reg6), 32'(m_bank[6]));
      chk("reg7", 32'(reg7), 32'(m_bank[7]));
      chk("immediate", 32'(immediate), 32'(m_bank[8]));
      chk("def_val", 32'(def_val), 32'(m_bank[9]));
      chk("wr_ready", 32'(wr_ready), 32'(m_q.size() < DEPTH));
      chk("busy", 32'(busy), 32'(m_q.size() != 0));
      chk("err_sel", 32'(err_sel), 32'(m_err));
    end
  end

  // Apply inputs just after a falling edge, then advance to the next falling edge.
  task automatic step(input bit v, input logic [3:0] s, input logic [15:0] d,
                      input bit ce, input bit clr);
    wr_valid  = v;
    wr_sel    = s;
    wr_data   = d;
    commit_en = ce;
    clear_err = clr;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    run_cmp = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(wr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_reg3", 32'(reg3), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single write, one-cycle latency
    step(1, 4'd3, 16'h1234, 1, 0);
    chk("single_busy_hi", 32'(busy), 32'd1);
    chk("single_reg3_not_yet", 32'(reg3), 32'd0);
    step(0, 4'd0, 16'h0, 1, 0);
    chk("single_reg3", 32'(reg3), 32'h1234);
    chk("single_busy_lo", 32'(busy), 32'd0);

    // backpressure
    step(1, 4'd0, 16'hAAAA, 0, 0);
    step(1, 4'd1, 16'hBBBB, 0, 0);
    chk("bp_full_ready", 32'(wr_ready), 32'd0);
    step(1, 4'd2, 16'hCCCC, 0, 0);
    chk("bp_held_reg0", 32'(reg0), 32'd0);
    step(1, 4'd2, 16'hCCCC, 1, 0);
    chk("bp_reg0", 32'(reg0), 32'hAAAA);
    chk("bp_ready_after_pop", 32'(wr_ready), 32'd1);
    step(1, 4'd2, 16'hCCCC, 1, 0);
    chk("bp_reg1", 32'(reg1), 32'hBBBB);
    chk("bp_reg2_not_yet", 32'(reg2), 32'd0);
    step(0, 4'd0, 16'h0, 1, 0);
    chk("bp_reg2", 32'(reg2), 32'hCCCC);

    // ordering / overwrite
    step(1, 4'd5, 16'h0001, 0, 0);
    step(1, 4'd5, 16'h0002, 0, 0);
    step(0, 4'd0, 16'h0, 1, 0);
    chk("ord_first", 32'(reg5), 32'h0001);
    step(0, 4'd0, 16'h0, 1, 0);
    chk("ord_second", 32'(reg5), 32'h0002);

    // special targets
    step(1, 4'd8, 16'h00FF, 1, 0);
    step(1, 4'd9, 16'hBEEF, 1, 0);
    chk("spec_imm", 32'(immediate), 32'h00FF);
    step(0, 4'd0, 16'h0, 1, 0);
    chk("spec_def", 32'(def_val), 32'hBEEF);
    chk("spec_reg0_kept", 32'(reg0), 32'hAAAA);

    // invalid select
    step(1, 4'd12, 16'hDEAD, 1, 0);
    chk("inv_err_set", 32'(err_sel), 32'd1);
    chk("inv_busy", 32'(busy), 32'd0);
    step(1, 4'd15, 16'h0, 1, 1);
    chk("inv_set_wins", 32'(err_sel), 32'd1);
    step(0, 4'd0, 16'h0, 1, 1);
    chk("inv_cleared", 32'(err_sel), 32'd0);

    // async reset mid-stream
    step(1, 4'd1, 16'h1111, 0, 0);
    step(1, 4'd2, 16'h2222, 0, 0);
    chk("ar_busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_reg0_async", 32'(reg0), 32'd0);
    chk("ar_def_async", 32'(def_val), 32'd0);
    chk("ar_busy_async", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 4'd0, 16'h0, 1, 0);
    step(0, 4'd0, 16'h0, 1, 0);
    chk("ar_ready", 32'(wr_ready), 32'd1);
    chk("ar_reg1_gone", 32'(reg1), 32'd0);
    chk("ar_reg2_gone", 32'(reg2), 32'd0);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      logic [3:0] s;
      s = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      wr_valid  = ($urandom_range(0, 3) != 0);
      wr_sel    = s;
      wr_data   = 16'($urandom);
      commit_en = ($urandom_range(0, 9) < 6);
      clear_err = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      @(negedge clk);
    end

    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/demux_writeback.md
Name: demux_writeback

Overview:
- Write-side counterpart of the operand-select mux in the bitty datapath.
- Accepts result writes through a valid/ready handshake, each tagged with a 4-bit destination select.
- Buffers writes in a small in-order queue and commits them into the register bank: reg0..reg7, immediate, def_val.
- The bank contents drive the operand-select mux inputs directly.

Parameters:
DATA_W, 16, width of every register and of wr_data
DEPTH, 2, write-queue entries (>=1); pointers wrap modulo DEPTH

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
wr_valid  input  1  write request present
wr_ready  output  1  queue can accept a write this cycle
wr_sel  input  4  destination: 0-7 reg0..reg7, 8 immediate, 9 def_val, 10-15 invalid
wr_data  input  DATA_W  write value
commit_en  input  1  permits head-of-queue commit this cycle (low = datapath stall)
clear_err  input  1  clears err_sel
reg0..reg7  output  DATA_W each  register bank contents
immediate  output  DATA_W  immediate register
def_val  output  DATA_W  default-value register
busy  output  1  queue non-empty
err_sel  output  1  sticky: a write with invalid select was accepted

Behaviour:
- Reset (rst_n low, asynchronous):
  - reg0..reg7, immediate and def_val go to 0.
  - Queue empties: count=0, read/write pointers 0.
  - err_sel=0, busy=0, wr_ready=1.
  - A reset mid-operation discards every queued write; nothing partially commits.
- Accept:
  - A write is accepted on a rising edge with wr_valid && wr_ready.
  - wr_ready = (count != DEPTH), purely from registered state, with no combinational path from wr_valid or commit_en.
  - When full, wr_ready=0 even if a commit drains an entry that same cycle; the slot frees on the following cycle.
  - wr_valid may stay asserted while wr_ready=0; wr_sel and wr_data are sampled only on the accepting edge.
- Invalid select (10-15):
  - The handshake completes normally.
  - Nothing is enqueued and count is unchanged.
  - err_sel sets on that edge.
  - err_sel clears on an edge with clear_err=1, unless an invalid accept occurs on the same edge; set wins.
- Commit:
  - On a rising edge with commit_en=1 and count>0, the head entry is written into its destination and popped.
  - At most one commit per cycle; strict FIFO order.
  - Registers not targeted hold their value.
- Latency:
  - Accepted at edge N into an empty queue with commit_en=1 at edge N+1: the value appears on the output after edge N+1.
  - Minimum latency is one cycle; no bypass from wr_data to the outputs.
- Simultaneous accept and commit:
  - Push at the write pointer and pop at the read pointer on the same edge; count unchanged.
  - Legal whenever wr_ready=1 and count>0.
- Same destination: two queued writes to the same register commit in order; the later value wins.
- busy = (count != 0), registered.
- commit_en low holds the queue and bank unchanged; acceptance continues until full.
- Pointer wrap: each pointer increments modulo DEPTH; no entry is lost or duplicated across the wrap.

Test Plan:
- Reset then single write: wr_sel=3, wr_data=0x1234, commit_en=1 -> reg3=0x1234 one edge after accept; all other outputs 0; busy high for exactly one cycle.
- Backpressure: commit_en=0, offer writes sel=0 data=0xAAAA, sel=1 data=0xBBBB, sel=2 data=0xCCCC -> first two accepted, wr_ready=0 with third held. Raise commit_en -> reg0=0xAAAA, then reg1=0xBBBB, then the third accepted and reg2=0xCCCC.
- Ordering and overwrite: queue sel=5 data=0x0001 then sel=5 data=0x0002 -> reg5 shows 0x0001 for one cycle, then 0x0002.
- Special targets: sel=8 data=0x00FF, sel=9 data=0xBEEF -> immediate=0x00FF, def_val=0xBEEF; reg0..reg7 unchanged.
- Invalid select: sel=12 data=0xDEAD accepted -> err_sel=1, no bank change, busy stays 0. Then clear_err=1 together with another sel=15 accept -> err_sel stays 1. clear_err alone -> err_sel=0.
- Async reset mid-stream: two queued writes with commit_en=0, drop rst_n between edges -> outputs 0 immediately; after release, busy=0, wr_ready=1, the queued writes never appear.
